// File: rtl/s2p_frame_rx.sv
// Framed serial-to-parallel receiver: header word, then NCH offset-corrected channel words, committed atomically with their floor average.
// Optional data-phase watchdog is built when S2P_FRAME_RX_TIMEOUT_EN is defined.
module s2p_frame_rx #(
  parameter int             NCH         = 4,
  parameter int             LOG2NCH     = 2,
  parameter int             DW          = 14,
  parameter logic [DW-1:0]  HEADER      = 'h0FFF,
  parameter int             TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sck,
  input  logic                cs,
  input  logic                mosi,
  input  logic                offset_we,
  input  logic [LOG2NCH-1:0]  offset_idx,
  input  logic [DW-1:0]       offset_wdata,
  output logic [NCH*DW-1:0]   ch_data,
  output logic [DW-1:0]       avg,
  output logic                frame_valid,
  output logic                frame_err
);

  localparam int CW = $clog2(DW + 2);

  typedef enum logic {HUNT, DATA} state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_sck_s, r_cs_s;
  logic [1:0]           r_mosi_s;
  logic                 r_close;
  logic [DW-1:0]        r_sr;
  logic [CW-1:0]        r_cnt;
  logic [LOG2NCH-1:0]   r_idx;
  logic [DW-1:0]        r_offset [NCH];
  logic [DW-1:0]        r_shadow [NCH];
  logic [NCH*DW-1:0]    r_ch;
  logic [DW-1:0]        r_avg;
  logic                 r_fv, r_fe;

  logic                 w_sck_rise, w_cs_rise, w_cs_fall, w_cs_low;
  logic                 w_wellformed, w_timeout;
  logic                 w_to_data, w_store, w_commit, w_err;
  logic [DW-1:0]        w_diff;
  logic [NCH*DW-1:0]    w_frame;

  // Sign-extended sum of all channels, arithmetic shift gives floor division by NCH.
  function automatic logic [DW-1:0] f_avg(input logic [NCH*DW-1:0] v);
    logic signed [DW+LOG2NCH-1:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++)
      s = s + {{LOG2NCH{v[i*DW+DW-1]}}, v[i*DW +: DW]};
    s = s >>> LOG2NCH;
    return s[DW-1:0];
  endfunction

  assign w_sck_rise   = r_sck_s[1] & ~r_sck_s[2];
  assign w_cs_rise    = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall    = ~r_cs_s[1] & r_cs_s[2];
  assign w_cs_low     = ~r_cs_s[1];
  assign w_wellformed = (r_cnt == CW'(DW));
  assign w_diff       = r_sr - r_offset[r_idx];

  // Stage 1: synchronisers, edge detect and bit capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_s  <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_close  <= 1'b0;
      r_sr     <= '0;
      r_cnt    <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[1:0], sck};
      r_cs_s   <= {r_cs_s[1:0], cs};
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_close  <= w_cs_rise;
      if (w_cs_fall) begin
        r_cnt <= '0;
      end else if (w_sck_rise && w_cs_low) begin
        r_sr <= {r_sr[DW-2:0], r_mosi_s[1]};
        if (r_cnt != CW'(DW + 1))
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef S2P_FRAME_RX_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] r_wdog;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_wdog <= '0;
    else if (r_state != DATA || r_close)
      r_wdog <= '0;
    else if (!w_timeout)
      r_wdog <= r_wdog + 1'b1;
  end

  assign w_timeout = (r_state == DATA) && (r_wdog == WDW'(TIMEOUT_CYC));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= HUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_data   = 1'b0;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      HUNT: begin
        if (r_close && w_wellformed && r_sr == HEADER) begin
          w_state_nxt = DATA;
          w_to_data   = 1'b1;
        end
      end
      DATA: begin
        if (r_close) begin
          if (w_wellformed) begin
            w_store = 1'b1;
            if (r_idx == LOG2NCH'(NCH - 1)) begin
              w_commit    = 1'b1;
              w_state_nxt = HUNT;
            end
          end else begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // The final word bypasses the shadow so it commits in its own close cycle.
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < NCH; i++)
      w_frame[i*DW +: DW] = (i == NCH - 1) ? w_diff : r_shadow[i];
  end

  // Stage 2: shadow capture, offsets and atomic commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_offset[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_ch  <= '0;
      r_avg <= '0;
      r_fv  <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      if (w_to_data)
        r_idx <= '0;
      else if (w_store)
        r_idx <= r_idx + 1'b1;
      if (w_store)
        r_shadow[r_idx] <= w_diff;
      if (offset_we)
        r_offset[offset_idx] <= offset_wdata;
      if (w_commit) begin
        r_ch  <= w_frame;
        r_avg <= f_avg(w_frame);
      end
      r_fv <= w_commit;
      r_fe <= w_err;
    end
  end

  assign ch_data     = r_ch;
  assign avg         = r_avg;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;

endmodule

// File: tb/tb_s2p_frame_rx.sv
// Scoreboard bench for s2p_frame_rx: a frame-level reference model queues expected commits/aborts, a monitor checks them.
module tb_s2p_frame_rx;
  localparam int            NCH     = 4;
  localparam int            LOG2NCH = 2;
  localparam int            DW      = 14;
  localparam logic [DW-1:0] HEADER  = 14'h0FFF;
  localparam int            MASK    = (1 << DW) - 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               sck = 1'b0;
  logic               cs = 1'b1;
  logic               mosi = 1'b0;
  logic               offset_we = 1'b0;
  logic [LOG2NCH-1:0] offset_idx = '0;
  logic [DW-1:0]      offset_wdata = '0;
  logic [NCH*DW-1:0]  ch_data;
  logic [DW-1:0]      avg;
  logic               frame_valid;
  logic               frame_err;

  s2p_frame_rx #(.NCH(NCH), .LOG2NCH(LOG2NCH), .DW(DW), .HEADER(HEADER), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .rstn(rstn), .sck(sck), .cs(cs), .mosi(mosi),
    .offset_we(offset_we), .offset_idx(offset_idx), .offset_wdata(offset_wdata),
    .ch_data(ch_data), .avg(avg), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                err;
    logic [NCH*DW-1:0] ch;
    logic [DW-1:0]     av;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: frame-level view of the protocol.
  bit                m_in_data = 0;
  int                m_k = 0;
  int                m_off [NCH];
  int                m_vals [NCH];
  logic [NCH*DW-1:0] m_ch = '0;
  logic [DW-1:0]     m_av = '0;

  function automatic int to_signed(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  task automatic model_reset();
    m_in_data = 0;
    m_k = 0;
    for (int i = 0; i < NCH; i++) m_off[i] = 0;
    m_ch = '0;
    m_av = '0;
  endtask

  task automatic model_close(input int w, input int nbits);
    exp_t e;
    int sum, qt;
    if (!m_in_data) begin
      if (nbits == DW && w == int'(HEADER)) begin
        m_in_data = 1;
        m_k = 0;
      end
    end else if (nbits != DW) begin
      e.err = 1; e.ch = m_ch; e.av = m_av;
      q.push_back(e);
      m_in_data = 0;
    end else begin
      m_vals[m_k] = (w - m_off[m_k]) & MASK;
      m_k++;
      if (m_k == NCH) begin
        sum = 0;
        for (int i = 0; i < NCH; i++) begin
          m_ch[i*DW +: DW] = DW'(m_vals[i]);
          sum += to_signed(m_vals[i]);
        end
        qt = sum / NCH;
        if (sum < 0 && (sum % NCH) != 0) qt = qt - 1;
        m_av = DW'(qt & MASK);
        e.err = 0; e.ch = m_ch; e.av = m_av;
        q.push_back(e);
        m_in_data = 0;
      end
    end
  endtask

  task automatic send_word(input int w, input int nbits);
    logic [31:0] tmp;
    tmp = w;
    cs = 1'b0;
    #40;
    for (int b = nbits - 1; b >= 0; b--) begin
      mosi = tmp[b];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    #40 cs = 1'b1;
    model_close(w, nbits);
    #80;
  endtask

  task automatic write_offset(input int idx, input int val);
    @(negedge clk);
    offset_we = 1'b1;
    offset_idx = LOG2NCH'(idx);
    offset_wdata = DW'(val);
    @(negedge clk);
    offset_we = 1'b0;
    m_off[idx] = val & MASK;
  endtask

  task automatic check_now(input string name, input logic [NCH*DW-1:0] act, input logic [NCH*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && (frame_valid || frame_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b with nothing expected", frame_valid, frame_err);
      end else begin
        e = q.pop_front();
        if (frame_valid !== !e.err || frame_err !== e.err) begin
          errors++;
          $display("FAIL pulse_kind: valid=%0b err=%0b, expected err=%0b", frame_valid, frame_err, e.err);
        end
        checks++;
        if (ch_data !== e.ch) begin
          errors++;
          $display("FAIL ch_data: got %h, expected %h", ch_data, e.ch);
        end
        checks++;
        if (avg !== e.av) begin
          errors++;
          $display("FAIL avg: got %h, expected %h", avg, e.av);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected pulses never seen, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic send_frame(input int hdr, input int d0, input int d1, input int d2, input int d3);
    send_word(hdr, DW);
    send_word(d0, DW);
    send_word(d1, DW);
    send_word(d2, DW);
    send_word(d3, DW);
  endtask

  initial begin
    int nb, w;
    model_reset();
    // Reset held while the serial pins toggle
    for (int i = 0; i < 10; i++) begin
      #20 sck = ~sck;
      cs = (i % 3 == 0);
    end
    cs = 1'b1; sck = 1'b0;
    check_now("reset_ch_data", ch_data, '0);
    check_now("reset_avg", {{(NCH*DW-DW){1'b0}}, avg}, '0);
    check_now("reset_valid", {{(NCH*DW-1){1'b0}}, frame_valid}, '0);
    check_now("reset_err", {{(NCH*DW-1){1'b0}}, frame_err}, '0);
    #23 rstn = 1'b1;
    repeat (20) @(negedge clk);

    // Known offsets and data
    write_offset(0, 1965); write_offset(1, 2080);
    write_offset(2, 2090); write_offset(3, 2100);
    send_frame(int'(HEADER), 2000, 2100, 2000, 2200);
    drain();
    check_now("basic_ch_data", ch_data, {14'd100, 14'h3FA6, 14'd20, 14'd35});
    check_now("basic_avg", {{(NCH*DW-DW){1'b0}}, avg}, {{(NCH*DW-DW){1'b0}}, 14'd16});

    // Negative floor average
    for (int i = 0; i < NCH; i++) write_offset(i, 0);
    send_frame(int'(HEADER), 'h3FFD, 'h3FFE, 'h3FFF, 'h3FFF);
    drain();
    check_now("neg_avg", {{(NCH*DW-DW){1'b0}}, avg}, {{(NCH*DW-DW){1'b0}}, 14'h3FFE});

    // Wrong header, then a good frame
    send_frame('h0FFE, 1, 2, 3, 4);
    send_frame(int'(HEADER), 10, 20, 30, 40);
    drain();

    // Short third data word aborts the frame
    send_word(int'(HEADER), DW);
    send_word(111, DW);
    send_word(222, DW);
    send_word(333, 13);
    drain();
    check_now("abort_keeps_ch", ch_data, m_ch);
    send_frame(int'(HEADER), 5, 6, 7, 8);
    drain();

    // Reset in the middle of a frame
    send_word(int'(HEADER), DW);
    send_word(500, DW);
    send_word(600, DW);
    rstn = 1'b0;
    model_reset();
    #1;
    check_now("midreset_ch", ch_data, '0);
    check_now("midreset_avg", {{(NCH*DW-DW){1'b0}}, avg}, '0);
    #30 rstn = 1'b1;
    repeat (5) @(negedge clk);
    send_word(700, DW);
    send_word(800, DW);
    repeat (20) @(negedge clk);
    check_now("midreset_ignored", ch_data, '0);

`ifdef S2P_FRAME_RX_TIMEOUT_EN
    // Header followed by silence trips the watchdog
    send_word(int'(HEADER), DW);
    begin
      exp_t e;
      e.err = 1; e.ch = m_ch; e.av = m_av;
      q.push_back(e);
      m_in_data = 0;
    end
    repeat (4200) @(negedge clk);
    drain();
    send_frame(int'(HEADER), 9, 10, 11, 12);
    drain();
`endif

    // Randomised frames with occasional bad headers and malformed words
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0)
        write_offset($urandom_range(0, NCH - 1), $urandom_range(0, MASK));
      send_word(($urandom_range(0, 9) == 0) ? $urandom_range(0, MASK) : int'(HEADER), DW);
      for (int i = 0; i < NCH; i++) begin
        nb = ($urandom_range(0, 19) == 0) ? ($urandom_range(0, 1) ? DW + 1 + $urandom_range(0, 1) : DW - 1 - $urandom_range(0, 1)) : DW;
        w = $urandom_range(0, MASK);
        send_word(w, nb);
      end
      drain();
    end
    check_now("final_ch_data", ch_data, m_ch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
